rice_bus_arbiter: RTL

RICE_BUS_ARBITER -- requirements
Module: rice_bus_arbiter

---
 rtl/rice_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rice_bus_arbiter.sv
// rice_bus_arbiter: two-master (instruction fetch m0, data m1) to one shared
// bus arbiter. Requests are passed through combinationally and responses are
// routed back in acceptance order using a small ID FIFO.
// Optional feature macro: RICE_BUS_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin on contention (pointer moves on each handshake)
//   undefined -> fixed priority, data master (m1) always wins contention
module rice_bus_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int REQ_W  = ADDRESS_WIDTH + 1 + DATA_WIDTH + STRB_W,
  localparam int RSP_W  = DATA_WIDTH + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_m0_request_valid,
  output logic             o_m0_request_ready,
  input  logic [REQ_W-1:0] i_m0_request,
  output logic             o_m0_response_valid,
  output logic [RSP_W-1:0] o_m0_response,
  input  logic             i_m1_request_valid,
  output logic             o_m1_request_ready,
  input  logic [REQ_W-1:0] i_m1_request,
  output logic             o_m1_response_valid,
  output logic [RSP_W-1:0] o_m1_response,
  output logic             o_request_valid,
  input  logic             i_request_ready,
  output logic [REQ_W-1:0] o_request,
  input  logic             i_response_valid,
  input  logic [RSP_W-1:0] i_response
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  // routing FIFO: one master-ID bit per outstanding request
  logic [MAX_OUTSTANDING-1:0] route_id;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  logic lock_valid;
  logic lock_id;
  logic sel;
  logic sel_valid;
  logic fifo_full;
  logic handshake;
  logic pop;
  logic head_id;

`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
  logic prefer;

  // priority pointer: the master not granted most recently wins next contention
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prefer <= 1'b1;
    end else if (handshake) begin
      prefer <= ~sel;
    end
  end
`endif

  // master selection: a pending (locked) request keeps its grant until handshake
  always_comb begin
    sel = 1'b0;
    if (lock_valid) begin
      sel = lock_id;
    end else if (i_m0_request_valid && i_m1_request_valid) begin
`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
      sel = prefer;
`else
      sel = 1'b1;
`endif
    end else if (i_m1_request_valid) begin
      sel = 1'b1;
    end
  end

  // request path: combinational pass-through, blocked while routing FIFO is full
  always_comb begin
    fifo_full          = (count == FULL_CNT);
    sel_valid          = sel ? i_m1_request_valid : i_m0_request_valid;
    o_request_valid    = sel_valid && !fifo_full && !i_rst;
    o_request          = o_request_valid ? (sel ? i_m1_request : i_m0_request) : '0;
    handshake          = o_request_valid && i_request_ready;
    o_m0_request_ready = i_request_ready && !sel && !fifo_full && !i_rst;
    o_m1_request_ready = i_request_ready &&  sel && !fifo_full && !i_rst;
  end

  // response path: route to the master at the FIFO head; drop if nothing is outstanding
  always_comb begin
    head_id             = route_id[rd_ptr];
    pop                 = i_response_valid && (count != '0) && !i_rst;
    o_m0_response_valid = pop && !head_id;
    o_m1_response_valid = pop &&  head_id;
    o_m0_response       = o_m0_response_valid ? i_response : '0;
    o_m1_response       = o_m1_response_valid ? i_response : '0;
  end

  // grant lock: set when a request is offered but not taken, cleared on handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
    end else if (handshake) begin
      lock_valid <= 1'b0;
    end else if (o_request_valid) begin
      lock_valid <= 1'b1;
      lock_id    <= sel;
    end
  end

  // routing FIFO pointers and occupancy; simultaneous push/pop keeps occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (handshake) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (handshake && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !handshake) begin
        count <= count - 1'b1;
      end
    end
  end

  // routing FIFO storage; contents are don't-care outside the valid window
  always_ff @(posedge i_clk) begin
    if (handshake) begin
      route_id[wr_ptr] <= sel;
    end
  end

endmodule
